// File: rtl/multi_ball_gen_pkg.sv
// rtl/multi_ball_gen_pkg.sv - shared helpers for the multi-ball motion engine
// Purpose: width derivation and reset-position helpers used by multi_ball_gen.
// Ports: none (package).
package multi_ball_gen_pkg;

  // Number of bits needed to hold values 0..value-1 (ceiling log2).
  function automatic int log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Reset x centre of ball i: evenly spread across the screen, then pulled
  // inside the legal centre range so the ball never starts in a wall.
  function automatic int init_x(input int i, input int width,
                                input int num_balls, input int radius);
    int x;
    x = ((2 * i + 1) * width) / (2 * num_balls);
    if (x < radius) x = radius;
    if (x > width - 1 - radius) x = width - 1 - radius;
    return x;
  endfunction

endpackage

// File: rtl/ball_axis_step.sv
// rtl/ball_axis_step.sv - one-axis position step with wall reflection
// Purpose: combinational p+v step, clamped to [lo, hi] with velocity reversal.
// Ports:
//   p      in   W      current centre coordinate
//   v      in   W+2    signed velocity
//   p_next out  W      stepped coordinate
//   v_next out  W+2    velocity after a possible reflection
//   hit    out  1      a reflection happened on this step
module ball_axis_step #(
  parameter int W  = 10,
  parameter int lo = 16,
  parameter int hi = 1007
) (
  input  logic [W-1:0]        p,
  input  logic signed [W+1:0] v,
  output logic [W-1:0]        p_next,
  output logic signed [W+1:0] v_next,
  output logic                hit
);

  localparam logic signed [W+1:0] LO = (W+2)'(lo);
  localparam logic signed [W+1:0] HI = (W+2)'(hi);

  // Two guard bits keep the sum from wrapping past either wall.
  logic signed [W+1:0] n;
  logic                v_pos_dir;
  logic                v_neg_dir;

  assign n         = $signed({2'b00, p}) + v;
  assign v_neg_dir = v[W+1];
  assign v_pos_dir = !v[W+1] && (v != '0);

  always_comb begin
    p_next = n[W-1:0];
    v_next = v;
    hit    = 1'b0;
    if (v_pos_dir && (n >= HI)) begin
      p_next = W'(hi);
      v_next = -v;
      hit    = 1'b1;
    end else if (v_neg_dir && (n <= LO)) begin
      p_next = W'(lo);
      v_next = -v;
      hit    = 1'b1;
    end
  end

endmodule

// File: rtl/multi_ball_gen.sv
// rtl/multi_ball_gen.sv - N-ball bouncing motion engine with atomic publish
// Purpose: on each move strobe, steps every ball once (one per clock), then
// publishes all positions together to the renderer.
// Ports:
//   clk        in   1             clock
//   reset      in   1             synchronous, active-high
//   move       in   1             frame strobe, starts a sweep when idle
//   pause      in   1             freeze positions during STEP cycles
//   h_pos      out  num_balls*XW  packed x centres, ball i at [i*XW +: XW]
//   v_pos      out  num_balls*YW  packed y centres
//   busy       out  1             sweep in progress
//   bounce_cnt out  16            saturating reflection count
//   overrun    out  1             sticky: move seen while busy
module multi_ball_gen
  import multi_ball_gen_pkg::*;
#(
  parameter int width       = 1024,
  parameter int height      = 768,
  parameter int num_balls   = 4,
  parameter int ball_radius = 16,
  parameter int speed       = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 move,
  input  logic                                 pause,
  output logic [num_balls*log2(width)-1:0]     h_pos,
  output logic [num_balls*log2(height)-1:0]    v_pos,
  output logic                                 busy,
  output logic [15:0]                          bounce_cnt,
  output logic                                 overrun
);

  localparam int XW = log2(width);
  localparam int YW = log2(height);
  localparam int IW = (log2(num_balls) > 1) ? log2(num_balls) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_STEP    = 2'd1;
  localparam logic [1:0] S_PUBLISH = 2'd2;

  localparam logic signed [XW+1:0] VX = (XW+2)'(speed);
  localparam logic signed [YW+1:0] VY = (YW+2)'(speed);
  localparam logic [IW-1:0]        LAST = IW'(num_balls - 1);

  logic [1:0]    state;
  logic [IW-1:0] idx;

  // Working state; only h_pos/v_pos are visible to the renderer.
  logic [XW-1:0]        x_r  [num_balls];
  logic [YW-1:0]        y_r  [num_balls];
  logic signed [XW+1:0] vx_r [num_balls];
  logic signed [YW+1:0] vy_r [num_balls];

  logic [XW-1:0]        x_nxt;
  logic [YW-1:0]        y_nxt;
  logic signed [XW+1:0] vx_nxt;
  logic signed [YW+1:0] vy_nxt;
  logic                 hit_x;
  logic                 hit_y;
  logic [16:0]          cnt_sum;
  logic [15:0]          cnt_sat;

  // One stepper per axis, time-shared across balls through the index mux.
  ball_axis_step #(.W(XW), .lo(ball_radius), .hi(width - 1 - ball_radius)) u_step_x (
    .p      (x_r[idx]),
    .v      (vx_r[idx]),
    .p_next (x_nxt),
    .v_next (vx_nxt),
    .hit    (hit_x)
  );

  ball_axis_step #(.W(YW), .lo(ball_radius), .hi(height - 1 - ball_radius)) u_step_y (
    .p      (y_r[idx]),
    .v      (vy_r[idx]),
    .p_next (y_nxt),
    .v_next (vy_nxt),
    .hit    (hit_y)
  );

  // A corner hit adds two; the count pins at all-ones.
  assign cnt_sum = {1'b0, bounce_cnt} + {16'd0, hit_x} + {16'd0, hit_y};
  assign cnt_sat = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      bounce_cnt <= '0;
      overrun    <= 1'b0;
      for (int i = 0; i < num_balls; i++) begin
        x_r[i]              <= XW'(init_x(i, width, num_balls, ball_radius));
        y_r[i]              <= YW'(height / 2);
        vx_r[i]             <= (i % 2 == 0) ? VX : -VX;
        vy_r[i]             <= (i % 2 == 0) ? -VY : VY;
        h_pos[i*XW +: XW]   <= XW'(init_x(i, width, num_balls, ball_radius));
        v_pos[i*YW +: YW]   <= YW'(height / 2);
      end
    end else begin
      if (move && busy) overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (move) begin
            state <= S_STEP;
            idx   <= '0;
          end
        end
        S_STEP: begin
          if (!pause) begin
            x_r[idx]   <= x_nxt;
            y_r[idx]   <= y_nxt;
            vx_r[idx]  <= vx_nxt;
            vy_r[idx]  <= vy_nxt;
            bounce_cnt <= cnt_sat;
          end
          if (idx == LAST) state <= S_PUBLISH;
          else             idx   <= idx + 1'b1;
        end
        S_PUBLISH: begin
          for (int i = 0; i < num_balls; i++) begin
            h_pos[i*XW +: XW] <= x_r[i];
            v_pos[i*YW +: YW] <= y_r[i];
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_ball_gen.sv
// tb/tb_multi_ball_gen.sv - self-checking bench for multi_ball_gen
module tb_multi_ball_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // d0: default configuration
  logic        rst0, mv0, ps0, b0, o0;
  logic [39:0] h0, v0;
  logic [15:0] c0;
  // d1: 64x48, one ball, r=4, speed=3
  logic        rst1, mv1, ps1, b1, o1;
  logic [5:0]  h1, v1;
  logic [15:0] c1;
  // d2: 256x128, three balls, r=8, speed=7 (random run)
  logic        rst2, mv2, ps2, b2, o2;
  logic [23:0] h2;
  logic [20:0] v2;
  logic [15:0] c2;

  multi_ball_gen u_d0 (
    .clk(clk), .reset(rst0), .move(mv0), .pause(ps0), .h_pos(h0), .v_pos(v0),
    .busy(b0), .bounce_cnt(c0), .overrun(o0)
  );

  multi_ball_gen #(.width(64), .height(48), .num_balls(1), .ball_radius(4), .speed(3)) u_d1 (
    .clk(clk), .reset(rst1), .move(mv1), .pause(ps1), .h_pos(h1), .v_pos(v1),
    .busy(b1), .bounce_cnt(c1), .overrun(o1)
  );

  multi_ball_gen #(.width(256), .height(128), .num_balls(3), .ball_radius(8), .speed(7)) u_d2 (
    .clk(clk), .reset(rst2), .move(mv2), .pause(ps2), .h_pos(h2), .v_pos(v2),
    .busy(b2), .bounce_cnt(c2), .overrun(o2)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct { int x; int y; } pos_t;
  typedef struct { int moves; int x; int y; int cnt; } vec1_t;

  pos_t  tab0 [4];
  vec1_t tab1 [3];

  localparam logic [39:0] INIT_H0 = {10'd896, 10'd640, 10'd384, 10'd128};
  localparam logic [39:0] INIT_V0 = {10'd384, 10'd384, 10'd384, 10'd384};

  // reference model state for d2
  int mx [3];
  int my [3];
  int mvx[3];
  int mvy[3];
  int mcnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic busy_of(input int d);
    case (d)
      0:       return b0;
      1:       return b1;
      default: return b2;
    endcase
  endfunction

  // Pulse move on DUT d for one edge, then wait (bounded) for busy to drop.
  // nb returns the number of sampled cycles with busy high.
  task automatic do_move(input int d, output int nb);
    int guard;
    case (d)
      0:       mv0 = 1'b1;
      1:       mv1 = 1'b1;
      default: mv2 = 1'b1;
    endcase
    tick();
    mv0 = 1'b0; mv1 = 1'b0; mv2 = 1'b0;
    nb = 0;
    guard = 0;
    while (busy_of(d) && guard < 40) begin
      nb++;
      guard++;
      tick();
    end
    if (guard >= 40) chk("busy_timeout", 64'(1), 64'(0));
  endtask

  // Spec rule for one axis: returns 1 on a reflection.
  function automatic int axis_move(input int p, input int v, input int lo, input int hi,
                                   output int np, output int nv);
    int n;
    n  = p + v;
    np = n;
    nv = v;
    if (v > 0 && n >= hi) begin np = hi; nv = -v; return 1; end
    if (v < 0 && n <= lo) begin np = lo; nv = -v; return 1; end
    return 0;
  endfunction

  task automatic check_d0_step(input string tag, input int k);
    // after k unpaused moves from reset, no ball has reached a wall yet
    logic [39:0] eh, ev;
    for (int i = 0; i < 4; i++) begin
      eh[i*10 +: 10] = 10'(tab0[i].x + ((i % 2 == 0) ? k - 1 : 1 - k));
      ev[i*10 +: 10] = 10'(tab0[i].y + ((i % 2 == 0) ? 1 - k : k - 1));
    end
    chk({tag, "_h"}, 64'(h0), 64'(eh));
    chk({tag, "_v"}, 64'(v0), 64'(ev));
  endtask

  initial begin
    int nb, chg, done, h;
    logic [39:0] h_before;
    logic [23:0] eh2;
    logic [20:0] ev2;

    tab0[0] = '{129, 383};
    tab0[1] = '{383, 385};
    tab0[2] = '{641, 383};
    tab0[3] = '{895, 385};
    tab1[0] = '{7, 53, 4, 1};
    tab1[1] = '{9, 59, 10, 2};
    tab1[2] = '{10, 56, 13, 2};

    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    mv0 = 1'b0; mv1 = 1'b0; mv2 = 1'b0;
    ps0 = 1'b0; ps1 = 1'b0; ps2 = 1'b0;
    tick(); tick();
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    tick();

    // ---- d0 reset state
    chk("rst_h", 64'(h0), 64'(INIT_H0));
    chk("rst_v", 64'(v0), 64'(INIT_V0));
    chk("rst_busy", 64'(b0), 64'(0));
    chk("rst_cnt", 64'(c0), 64'(0));
    chk("rst_ovr", 64'(o0), 64'(0));

    // ---- d0 first move: busy length and publish edge
    mv0 = 1'b1;
    tick();
    mv0 = 1'b0;
    nb = 0;
    chg = -1;
    for (int k = 0; k < 8; k++) begin
      if (b0) nb++;
      if (chg < 0 && h0 != INIT_H0) chg = k;
      tick();
    end
    chk("busy_len", 64'(nb), 64'(5));
    chk("publish_edge", 64'(chg), 64'(5));
    for (int i = 0; i < 4; i++) begin
      chk("mv1_x", 64'(h0[i*10 +: 10]), 64'(tab0[i].x));
      chk("mv1_y", 64'(v0[i*10 +: 10]), 64'(tab0[i].y));
    end

    // ---- d0 overrun: second move two cycles into the sweep
    mv0 = 1'b1;
    tick();
    mv0 = 1'b0;
    tick();
    mv0 = 1'b1;
    tick();
    mv0 = 1'b0;
    done = 0;
    while (b0 && done < 40) begin done++; tick(); end
    chk("ovr_set", 64'(o0), 64'(1));
    check_d0_step("ovr_once", 2);
    repeat (8) tick();
    chk("ovr_no_resweep", 64'(b0), 64'(0));
    check_d0_step("ovr_stable", 2);
    do_move(0, nb);
    chk("ovr_sticky", 64'(o0), 64'(1));
    check_d0_step("mv3", 3);

    // ---- d0 pause over three moves
    ps0 = 1'b1;
    for (int m = 0; m < 3; m++) begin
      do_move(0, nb);
      chk("pause_busy", 64'(nb), 64'(5));
      check_d0_step("pause", 3);
      chk("pause_cnt", 64'(c0), 64'(0));
    end
    ps0 = 1'b0;

    // ---- d0 reset mid-sweep
    mv0 = 1'b1;
    tick();
    mv0 = 1'b0;
    tick();
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    chk("midrst_h", 64'(h0), 64'(INIT_H0));
    chk("midrst_v", 64'(v0), 64'(INIT_V0));
    chk("midrst_busy", 64'(b0), 64'(0));
    chk("midrst_ovr", 64'(o0), 64'(0));
    h_before = INIT_H0;
    repeat (6) tick();
    chk("midrst_nopub", 64'(h0), 64'(h_before));

    // ---- d1 table: small screen, single ball, exact-limit landings
    chk("d1_init_x", 64'(h1), 64'(32));
    chk("d1_init_y", 64'(v1), 64'(24));
    done = 0;
    for (int r = 0; r < 3; r++) begin
      while (done < tab1[r].moves) begin
        do_move(1, nb);
        done++;
      end
      chk("d1_x", 64'(h1), 64'(tab1[r].x));
      chk("d1_y", 64'(v1), 64'(tab1[r].y));
      chk("d1_cnt", 64'(c1), 64'(tab1[r].cnt));
    end
    chk("d1_ovr", 64'(o1), 64'(0));

    // ---- d2 random run against the model
    for (int i = 0; i < 3; i++) begin
      mx[i] = ((2 * i + 1) * 256) / 6;
      if (mx[i] < 8) mx[i] = 8;
      if (mx[i] > 247) mx[i] = 247;
      my[i]  = 64;
      mvx[i] = (i % 2 == 0) ? 7 : -7;
      mvy[i] = (i % 2 == 0) ? -7 : 7;
    end
    mcnt = 0;
    for (int m = 0; m < 300; m++) begin
      ps2 = ($urandom_range(0, 3) == 0);
      do_move(2, nb);
      chk("d2_busy", 64'(nb), 64'(4));
      if (!ps2) begin
        for (int i = 0; i < 3; i++) begin
          h = axis_move(mx[i], mvx[i], 8, 247, mx[i], mvx[i]);
          h += axis_move(my[i], mvy[i], 8, 119, my[i], mvy[i]);
          mcnt = (mcnt + h > 65535) ? 65535 : mcnt + h;
        end
      end
      for (int i = 0; i < 3; i++) begin
        eh2[i*8 +: 8] = 8'(mx[i]);
        ev2[i*7 +: 7] = 7'(my[i]);
      end
      chk("d2_h", 64'(h2), 64'(eh2));
      chk("d2_v", 64'(v2), 64'(ev2));
      chk("d2_cnt", 64'(c2), 64'(mcnt));
      ps2 = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    chk("d2_ovr", 64'(o2), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
